// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC fetch controller: FSM state encoding,
// default PC increment and a small alignment helper.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_ERR    = 2'd3
  } pc_state_e;

  localparam logic [31:0] PC_INC_DEFAULT = 32'd4;

  // A fetch target is legal only when it lands on a 32-bit word boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle between the PC stage and the next-PC mux / instruction
// memory. The master is the PC stage; the slave is everything around it.
interface pc_fetch_ctrl_if;
  logic [31:0] Address;
  logic        FetchReady;
  logic        Stall;
  logic        Halt;
  logic [31:0] PCResult;
  logic [31:0] PCPlus4;
  logic        PCValid;
  logic        AlignErr;
  logic [31:0] InstrCount;

  modport master (
    input  Address, FetchReady, Stall, Halt,
    output PCResult, PCPlus4, PCValid, AlignErr, InstrCount
  );

  modport slave (
    output Address, FetchReady, Stall, Halt,
    input  PCResult, PCPlus4, PCValid, AlignErr, InstrCount
  );
endinterface

// File: rtl/pc_adder32.sv
// Plain 32-bit combinational adder; the carry out is intentionally dropped.
module pc_adder32 (
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic [31:0] out
);

  // Modulo-2^32 sum.
  always_comb begin
    out = inA + inB;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter stage: holds the PC, offers PC+increment to the next-PC
// mux, registers the mux output on each accepted fetch, sequences boot,
// halt and misalignment error, and counts retired fetches.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
  parameter logic [31:0] PC_INC      = PC_INC_DEFAULT,
  parameter int          BOOT_CYCLES = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  pc_fetch_ctrl_if.master bus
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  pc_state_e   state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus_inc;
  logic [31:0] cnt_inc;
  logic        fire;

  // PCPlus4 towards the mux inA.
  pc_adder32 u_pc_add (
    .inA (pc_q),
    .inB (PC_INC),
    .out (pc_plus_inc)
  );

  // Retired-fetch counter increment; wraps naturally at 2^32.
  pc_adder32 u_cnt_add (
    .inA (cnt_q),
    .inB (32'd1),
    .out (cnt_inc)
  );

  // Stall wins over FetchReady: a stalled cycle never accepts a fetch.
  always_comb begin
    fire = bus.FetchReady & ~bus.Stall;
  end

  // Next-state and register updates for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    err_d      = err_q;

    unique case (state_q)
      S_BOOT: begin
        valid_d    = 1'b0;
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
          valid_d = 1'b1;
        end
      end
      S_RUN: begin
        valid_d = 1'b1;
        if (fire && !is_word_aligned(bus.Address)) begin
          // Error outranks halt; the bad target is never loaded.
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = S_ERR;
        end else begin
          if (fire) begin
            pc_d  = bus.Address;
            cnt_d = cnt_inc;
          end
          // An aligned fetch on the halting edge still commits.
          if (bus.Halt) begin
            valid_d = 1'b0;
            state_d = S_HALTED;
          end
        end
      end
      S_HALTED: begin
        valid_d = 1'b0;
      end
      S_ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = S_BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= 4'd0;
      pc_q       <= RESET_ADDR;
      cnt_q      <= 32'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.PCPlus4    = pc_plus_inc;
  assign bus.PCValid    = valid_q;
  assign bus.AlignErr   = err_q;
  assign bus.InstrCount = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a behavioural reference tracks
// what the PC stage must show, a compare process checks it every falling
// edge, and directed scenarios add hand-computed literal checks.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] INC    = 32'd4;
  localparam int          NBOOT  = 2;

  localparam int MB = 0;  // booting
  localparam int MR = 1;  // running
  localparam int MH = 2;  // halted
  localparam int ME = 3;  // error

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .RESET_ADDR  (RST_PC),
    .PC_INC      (INC),
    .BOOT_CYCLES (NBOOT)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_valid;
  logic        m_err;
  int          m_mode;
  int          m_boot_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc        <= RST_PC;
      m_cnt       <= 32'd0;
      m_valid     <= 1'b0;
      m_err       <= 1'b0;
      m_mode      <= MB;
      m_boot_left <= NBOOT;
    end else if (m_mode == MB) begin
      m_boot_left <= m_boot_left - 1;
      if (m_boot_left == 1) begin
        m_mode  <= MR;
        m_valid <= 1'b1;
      end
    end else if (m_mode == MR) begin
      if (bus.FetchReady && !bus.Stall && (bus.Address % 4 != 0)) begin
        m_err   <= 1'b1;
        m_valid <= 1'b0;
        m_mode  <= ME;
      end else begin
        if (bus.FetchReady && !bus.Stall) begin
          m_pc  <= bus.Address;
          m_cnt <= m_cnt + 32'd1;
        end
        if (bus.Halt) begin
          m_valid <= 1'b0;
          m_mode  <= MH;
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the reference model.
  always @(negedge clk) begin
    check32("model_pc",    bus.PCResult,   m_pc);
    check32("model_plus4", bus.PCPlus4,    m_pc + INC);
    check32("model_cnt",   bus.InstrCount, m_cnt);
    check32("model_valid", {31'd0, bus.PCValid},  {31'd0, m_valid});
    check32("model_err",   {31'd0, bus.AlignErr}, {31'd0, m_err});
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fire_addr(input logic [31:0] a);
    bus.Address    = a;
    bus.FetchReady = 1'b1;
    bus.Stall      = 1'b0;
    tick();
    bus.FetchReady = 1'b0;
  endtask

  task automatic reboot();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (NBOOT) tick();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.Address    = 32'd0;
    bus.FetchReady = 1'b0;
    bus.Stall      = 1'b0;
    bus.Halt       = 1'b0;

    // 1: reset and boot
    repeat (3) tick();
    check32("rst_pc",    bus.PCResult,   32'h0000_0000);
    check32("rst_plus4", bus.PCPlus4,    32'h0000_0004);
    check32("rst_cnt",   bus.InstrCount, 32'd0);
    check32("rst_valid", {31'd0, bus.PCValid},  32'd0);
    check32("rst_err",   {31'd0, bus.AlignErr}, 32'd0);
    rst_n = 1'b1;
    tick();
    check32("boot1_valid", {31'd0, bus.PCValid}, 32'd0);
    tick();
    check32("boot2_valid", {31'd0, bus.PCValid}, 32'd1);

    // 2: first fetch
    fire_addr(32'h0000_0004);
    check32("t2_pc",    bus.PCResult,   32'h0000_0004);
    check32("t2_plus4", bus.PCPlus4,    32'h0000_0008);
    check32("t2_cnt",   bus.InstrCount, 32'd1);

    // 3: stall, then not-ready, then accept
    bus.Address    = 32'h0000_0100;
    bus.FetchReady = 1'b1;
    bus.Stall      = 1'b1;
    repeat (2) tick();
    check32("t3_stall_pc",  bus.PCResult,   32'h0000_0004);
    check32("t3_stall_cnt", bus.InstrCount, 32'd1);
    bus.Stall      = 1'b0;
    bus.FetchReady = 1'b0;
    tick();
    check32("t3_nrdy_pc", bus.PCResult, 32'h0000_0004);
    fire_addr(32'h0000_0100);
    check32("t3_pc",  bus.PCResult,   32'h0000_0100);
    check32("t3_cnt", bus.InstrCount, 32'd2);

    // 4: misaligned target
    fire_addr(32'h0000_0102);
    check32("t4_err",   {31'd0, bus.AlignErr}, 32'd1);
    check32("t4_valid", {31'd0, bus.PCValid},  32'd0);
    check32("t4_pc",    bus.PCResult,   32'h0000_0100);
    check32("t4_cnt",   bus.InstrCount, 32'd2);
    fire_addr(32'h0000_0200);
    check32("t4_ign_pc", bus.PCResult, 32'h0000_0100);
    check32("t4_ign_err", {31'd0, bus.AlignErr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check32("t4_rst_err", {31'd0, bus.AlignErr}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (NBOOT) tick();
    check32("t4_reboot_valid", {31'd0, bus.PCValid}, 32'd1);

    // 5: PCPlus4 wrap, halt with simultaneous fetch
    fire_addr(32'hFFFF_FFFC);
    check32("t5_pc",    bus.PCResult, 32'hFFFF_FFFC);
    check32("t5_plus4", bus.PCPlus4,  32'h0000_0000);
    bus.Halt = 1'b1;
    fire_addr(32'h0000_0000);
    bus.Halt = 1'b0;
    check32("t5_halt_pc",    bus.PCResult,   32'h0000_0000);
    check32("t5_halt_cnt",   bus.InstrCount, 32'd2);
    check32("t5_halt_valid", {31'd0, bus.PCValid}, 32'd0);
    bus.Address    = 32'h0000_0008;
    bus.FetchReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("t5_held_valid", {31'd0, bus.PCValid}, 32'd0);
    end
    bus.FetchReady = 1'b0;
    check32("t5_held_pc",  bus.PCResult,   32'h0000_0000);
    check32("t5_held_cnt", bus.InstrCount, 32'd2);

    // Halt while stalled: nothing commits, fetching stops
    reboot();
    bus.Halt  = 1'b1;
    bus.Stall = 1'b1;
    bus.FetchReady = 1'b1;
    bus.Address = 32'h0000_0040;
    tick();
    bus.Halt  = 1'b0;
    bus.Stall = 1'b0;
    bus.FetchReady = 1'b0;
    check32("hs_pc",    bus.PCResult,   32'h0000_0000);
    check32("hs_cnt",   bus.InstrCount, 32'd0);
    check32("hs_valid", {31'd0, bus.PCValid}, 32'd0);
    fire_addr(32'h0000_0080);
    check32("hs_ign_pc", bus.PCResult, 32'h0000_0000);

    // Misaligned fetch together with halt goes to error
    reboot();
    bus.Halt = 1'b1;
    fire_addr(32'h0000_0006);
    bus.Halt = 1'b0;
    check32("eh_err", {31'd0, bus.AlignErr}, 32'd1);
    check32("eh_pc",  bus.PCResult, 32'h0000_0000);

    // 6: asynchronous reset mid-run
    reboot();
    fire_addr(32'h0000_0040);
    fire_addr(32'h0000_0044);
    check32("t6_pre_pc",  bus.PCResult,   32'h0000_0044);
    check32("t6_pre_cnt", bus.InstrCount, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check32("t6_pc",    bus.PCResult,   32'h0000_0000);
    check32("t6_cnt",   bus.InstrCount, 32'd0);
    check32("t6_valid", {31'd0, bus.PCValid}, 32'd0);
    check32("t6_plus4", bus.PCPlus4,    32'h0000_0004);
    tick();
    rst_n = 1'b1;
    tick();
    check32("t6_boot_valid", {31'd0, bus.PCValid}, 32'd0);
    tick();
    check32("t6_run_valid", {31'd0, bus.PCValid}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
